f1_loader: RTL

- Upstream stage of the conv-layer-1 feature RAM.
- Accepts the input image as an 8-bit pixel stream over a valid/ready handshake.
- Packs every 4 consecutive pixels into one 32-bit little-endian word.
- Issues byte-addressed, word-aligned writes on the feature RAM write port (wr_en / waddr / wdata / ena), then signals frame completion so conv layer 1 can start reading.

---
 rtl/f1_pkg.sv | 13 +
 rtl/f1_byte_packer.sv | 45 ++++
 rtl/f1_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// Shared constants and loader state encoding for the conv-layer-1 feature RAM.
package f1_pkg;
  localparam int F1_NUM_PIX    = 1024;
  localparam int F1_RADDR_W    = 10;
  localparam int F1_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAST,
    ST_DONE
  } f1_state_e;
endpackage

// File: rtl/f1_byte_packer.sv
// Packs a byte stream into little-endian words; emits a word on lane wrap or flush.
module f1_byte_packer
  import f1_pkg::*;
#(
  parameter int NUM_LANES = F1_WORD_BYTES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_vld,
  input  logic [7:0]                    in_byte,
  input  logic                          flush,
  output logic                          out_vld,
  output logic [NUM_LANES-1:0]          out_be,
  output logic [NUM_LANES-1:0][7:0]     out_word
);
  localparam int LW = $clog2(NUM_LANES);

  logic [LW-1:0]                lane_q;
  // The top lane is never stored: it is taken straight from in_byte.
  logic [NUM_LANES-2:0][7:0]    asm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lane_q <= '0;
    else if (clr)    lane_q <= '0;
    else if (in_vld) lane_q <= lane_q + 1'b1;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign out_be[k] = (LW'(k) <= lane_q);
    if (k < NUM_LANES - 1) begin : g_store
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            asm_q[k] <= '0;
        else if (clr)                          asm_q[k] <= '0;
        else if (in_vld && lane_q == LW'(k))   asm_q[k] <= in_byte;
      end
      assign out_word[k] = !out_be[k] ? 8'h00 :
                           (lane_q == LW'(k)) ? in_byte : asm_q[k];
    end else begin : g_top
      assign out_word[k] = out_be[k] ? in_byte : 8'h00;
    end
  end

  assign out_vld = in_vld && (flush || lane_q == LW'(NUM_LANES - 1));
endmodule

// File: rtl/f1_loader.sv
// Frame loader: streams pixels into packed word writes on the f1 feature RAM port.
module f1_loader
  import f1_pkg::*;
#(
  parameter int          NUM_PIX   = F1_NUM_PIX,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [3:0]  f1_wr_en,
  output logic [31:0] f1_waddr,
  output logic [31:0] f1_wdata,
  output logic        f1_ena,
  output logic        busy,
  output logic        done
);
  f1_state_e state_q, state_d;
  logic [10:0] cnt_q;
  logic        go, accept, last_pix;
  logic        pk_vld;
  logic [3:0]  pk_be;
  logic [3:0][7:0] pk_word;

  assign go       = (state_q == ST_IDLE) && start;
  assign accept   = pix_valid && pix_ready;
  assign last_pix = accept && (cnt_q == 11'(NUM_PIX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (go)          cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 11'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (last_pix) state_d = ST_LAST;
      end
      ST_LAST: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  f1_byte_packer #(.NUM_LANES(F1_WORD_BYTES)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (go),
    .in_vld   (accept),
    .in_byte  (pix_data),
    .flush    (last_pix),
    .out_vld  (pk_vld),
    .out_be   (pk_be),
    .out_word (pk_word)
  );

  // Write strobes are single-cycle: everything drops back to zero unless a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_wr_en <= '0;
      f1_waddr <= '0;
      f1_wdata <= '0;
      f1_ena   <= 1'b0;
    end else if (pk_vld) begin
      f1_wr_en <= pk_be;
      f1_waddr <= BASE_ADDR + {21'd0, cnt_q[10:2], 2'b00};
      f1_wdata <= pk_word;
      f1_ena   <= |pk_be;
    end else begin
      f1_wr_en <= '0;
      f1_waddr <= '0;
      f1_wdata <= '0;
      f1_ena   <= 1'b0;
    end
  end
endmodule
